// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 4-digit display scanner.
// Each digit is lit for DIV cycles and then blanked for DEAD cycles.
// New display words are double-buffered and committed only at the
// 3->0 frame wrap (or at once while the scanner is off), so disp never
// changes in the middle of a frame.
// Every output is a register. an is computed from next-state values so
// that it lines up with state/sel in the same cycle.
module display_scan_ctrl #(
  parameter int DIV  = 100000,
  parameter int DEAD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic [15:0] disp,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic        load_ack
);

  localparam int CMAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = (DEAD > 0) ? CW'(DEAD - 1) : {CW{1'b0}};

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    sel_r, sel_s;
  logic [3:0]    an_r, an_s;
  logic [15:0]   disp_r, disp_s;
  logic [15:0]   pend_r;
  logic          pend_v_r;
  logic          load_ack_r;
  logic          wrap_s;
  logic          commit_s;
  logic          blank_digit_s;
  logic          z3_s, z2_s, z1_s;

  // Next-state logic for the scan FSM, counter and digit select.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sel_s   = sel_r;
    wrap_s  = 1'b0;
    if (!enable) begin
      state_s = ST_OFF;
      cnt_s   = {CW{1'b0}};
      sel_s   = 2'd0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_s = ST_SHOW;
          cnt_s   = {CW{1'b0}};
          sel_s   = 2'd0;
        end
        ST_SHOW: begin
          if (cnt_r == DIV_LAST) begin
            cnt_s = {CW{1'b0}};
            if (DEAD == 0) begin
              // No blanking: step straight to the next digit.
              sel_s  = sel_r + 2'd1;
              wrap_s = (sel_r == 2'd3);
            end else begin
              state_s = ST_BLANK;
            end
          end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_BLANK: begin
          if (cnt_r == DEAD_LAST) begin
            cnt_s   = {CW{1'b0}};
            sel_s   = sel_r + 2'd1;
            state_s = ST_SHOW;
            wrap_s  = (sel_r == 2'd3);
          end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_s = ST_OFF;
          cnt_s   = {CW{1'b0}};
          sel_s   = 2'd0;
        end
      endcase
    end
  end

  // Commit decision and the display word that will be visible next cycle.
  always_comb begin
    if (state_r == ST_OFF) begin
      commit_s = pend_v_r;
    end else begin
      commit_s = wrap_s & pend_v_r;
    end
    if (commit_s) begin
      disp_s = pend_r;
    end else begin
      disp_s = disp_r;
    end
  end

  // Anode pattern for next cycle, including leading-zero suppression.
  always_comb begin
    z3_s = (disp_s[15:12] == 4'h0);
    z2_s = z3_s & (disp_s[11:8] == 4'h0);
    z1_s = z2_s & (disp_s[7:4] == 4'h0);
    case (sel_s)
      2'd3:    blank_digit_s = lz_en & z3_s;
      2'd2:    blank_digit_s = lz_en & z2_s;
      2'd1:    blank_digit_s = lz_en & z1_s;
      default: blank_digit_s = 1'b0;
    endcase
    if ((state_s == ST_SHOW) && !blank_digit_s) begin
      an_s = ~(4'b0001 << sel_s);
    end else begin
      an_s = 4'b1111;
    end
  end

  // Scan state, counter, select and anode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
      cnt_r   <= {CW{1'b0}};
      sel_r   <= 2'd0;
      an_r    <= 4'b1111;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      an_r    <= an_s;
    end
  end

  // Pending buffer, committed display word and acknowledge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r     <= 16'h0000;
      pend_v_r   <= 1'b0;
      disp_r     <= 16'h0000;
      load_ack_r <= 1'b0;
    end else begin
      if (load) begin
        pend_r <= value;
      end else begin
        pend_r <= pend_r;
      end
      // A load in the commit cycle re-arms the buffer with the new word.
      pend_v_r   <= load | (pend_v_r & ~commit_s);
      disp_r     <= disp_s;
      load_ack_r <= commit_s;
    end
  end

  assign disp     = disp_r;
  assign sel      = sel_r;
  assign an       = an_r;
  assign load_ack = load_ack_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: two instances (DEAD=2 and DEAD=0, both
// DIV=4) share stimulus and are compared each cycle against a frame-position
// model: digit = pos / (DIV+DEAD), lit while pos % (DIV+DEAD) < DIV.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        lz_en = 1'b0;

  logic [15:0] disp_a, disp_b;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  an_a, an_b;
  logic        ack_a, ack_b;

  int total = 0;
  int bad = 0;

  display_scan_ctrl #(.DIV(DIV), .DEAD(2)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .lz_en(lz_en), .disp(disp_a), .sel(sel_a), .an(an_a), .load_ack(ack_a)
  );

  display_scan_ctrl #(.DIV(DIV), .DEAD(0)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .lz_en(lz_en), .disp(disp_b), .sel(sel_b), .an(an_b), .load_ack(ack_b)
  );

  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  int          m_dead [2] = '{2, 0};
  bit          m_run  [2];
  int          m_pos  [2];
  logic [15:0] m_disp [2];
  logic [15:0] m_pend [2];
  bit          m_pv   [2];
  bit          m_ack  [2];
  bit          m_lz   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_disp[i] = 16'h0000; m_pend[i] = 16'h0000;
      m_pv[i] = 0; m_ack[i] = 0; m_lz[i] = 0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      int frame;
      bit commit;
      frame = 4 * (DIV + m_dead[i]);
      commit = m_pv[i] && (!m_run[i] || (enable && m_pos[i] == frame - 1));
      m_ack[i] = commit;
      if (commit) m_disp[i] = m_pend[i];
      if (load) begin
        m_pend[i] = value;
        m_pv[i] = 1;
      end else if (commit) begin
        m_pv[i] = 0;
      end
      m_lz[i] = lz_en;
      m_pos[i] = (m_run[i] && enable) ? (m_pos[i] + 1) % frame : 0;
      m_run[i] = enable;
    end
  endtask

  function automatic logic [1:0] exp_sel(int i);
    if (!m_run[i]) return 2'd0;
    return 2'(m_pos[i] / (DIV + m_dead[i]));
  endfunction

  function automatic logic [3:0] exp_an(int i);
    int per, d;
    logic [3:0] one;
    one = 4'b0001;
    if (!m_run[i]) return 4'b1111;
    per = DIV + m_dead[i];
    d = m_pos[i] / per;
    if (m_pos[i] % per >= DIV) return 4'b1111;
    if (m_lz[i] && d > 0 && (m_disp[i] >> (4 * d)) == 16'h0000) return 4'b1111;
    return ~(one << d);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("an_a",   {12'h000, an_a},   {12'h000, exp_an(0)});
    chk("sel_a",  {14'h0000, sel_a}, {14'h0000, exp_sel(0)});
    chk("disp_a", disp_a,            m_disp[0]);
    chk("ack_a",  {15'h0000, ack_a}, {15'h0000, m_ack[0]});
    chk("an_b",   {12'h000, an_b},   {12'h000, exp_an(1)});
    chk("sel_b",  {14'h0000, sel_b}, {14'h0000, exp_sel(1)});
    chk("disp_b", disp_b,            m_disp[1]);
    chk("ack_b",  {15'h0000, ack_b}, {15'h0000, m_ack[1]});
    chk("onehot_a", 16'($countones(~an_a) <= 1), 16'h0001);
    chk("onehot_b", 16'($countones(~an_b) <= 1), 16'h0001);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_clock();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Step until instance A shows digit s lit; a timeout is a failed check.
  task automatic wait_lit(input logic [1:0] s);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      if (sel_a == s && an_a != 4'b1111) ok = 1;
    end
    chk("wait_lit", {15'h0000, ok}, 16'h0001);
  endtask

  int acks;
  bit saw_abcd;

  initial begin
    model_reset();
    // Reset state while reset is held.
    run(2);
    chk("rst_an", {12'h000, an_a}, 16'h000F);
    chk("rst_disp", disp_a, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Load while off: acknowledged on the following cycle.
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    step();
    chk("off_ack", {15'h0000, ack_a}, 16'h0001);
    chk("off_disp", disp_a, 16'h1234);
    step();
    chk("off_ack_end", {15'h0000, ack_a}, 16'h0000);

    // Basic scan: first lit cycle is digit 0.
    enable = 1'b1;
    step();
    chk("scan_first", {12'h000, an_a}, 16'h000E);
    run(50);

    // Frame-boundary commit: two loads mid-frame, last one wins.
    wait_lit(2'd1);
    load = 1'b1; value = 16'hABCD;
    step();
    load = 1'b0;
    step();
    load = 1'b1; value = 16'h5678;
    step();
    load = 1'b0;
    chk("mid_hold", disp_a, 16'h1234);
    acks = 0; saw_abcd = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (ack_a) acks++;
      if (disp_a == 16'hABCD) saw_abcd = 1;
    end
    chk("one_ack", 16'(acks), 16'h0001);
    chk("no_abcd", {15'h0000, saw_abcd}, 16'h0000);
    chk("new_disp", disp_a, 16'h5678);

    // Leading-zero suppression, then all digits lit again.
    load = 1'b1; value = 16'h0050; lz_en = 1'b1;
    step();
    load = 1'b0;
    run(60);
    chk("lz_disp", disp_a, 16'h0050);
    lz_en = 1'b0;
    run(30);

    // Enable drop during digit 2, then restart from digit 0.
    wait_lit(2'd2);
    enable = 1'b0;
    step();
    chk("drop_an", {12'h000, an_a}, 16'h000F);
    chk("drop_sel", {14'h0000, sel_a}, 16'h0000);
    step();
    enable = 1'b1;
    step();
    chk("restart_an", {12'h000, an_a}, 16'h000E);
    run(10);

    // Asynchronous reset between edges with a word pending.
    load = 1'b1; value = 16'h9999;
    step();
    load = 1'b0;
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_an", {12'h000, an_a}, 16'h000F);
    chk("arst_disp", disp_a, 16'h0000);
    chk("arst_ack", {15'h0000, ack_a}, 16'h0000);
    step();
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (ack_a) acks++;
    end
    chk("arst_noack", 16'(acks), 16'h0000);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      enable = ($urandom_range(0, 24) != 0);
      load = ($urandom_range(0, 9) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 9) < 3) value[15:8] = 8'h00;
      if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
